conv_scheduler: RTL
===================

# conv_scheduler

Round-robin scheduler that shares one `converter` unit between `NREQ` independent requesters. It accepts one conversion job at a time, drives the converter's `type`/`select`/`reverse` controls one full cycle before asserting `valid_in`, so the converter's negedge-latched conversion factors settle first. It then waits for `valid_out` with a timeout and returns the result, tagged with the requester ID, through a valid/ready response port. It sits between the request fabric and the `converter` instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester ID width, equal to clog2(`NREQ`).
- `TIMEOUT`, 64: maximum number of WAIT cycles before a job is aborted; must be at least 4.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in `NREQ`: per-requester job request.
- `req_ready` out `NREQ`: one-hot acceptance pulse.
- `req_number` in `NREQ*32`: IEEE-754 single-precision operand; requester i occupies bits [32i+31:32i].
- `req_type` in `NREQ*2`: conversion type for each requester.
- `req_select` in `NREQ*3`: conversion select for each requester.
- `req_reverse` in `NREQ`: reverse flag for each requester.
- `cv_number_in` out 32: operand to the converter.
- `cv_valid_in` out 1: start pulse to the converter.
- `cv_type` out 2: type to the converter.
- `cv_select` out 3: select to the converter.
- `cv_reverse` out 1: reverse flag to the converter.
- `cv_number_out` in 32: converter result.
- `cv_valid_out` in 1: converter done.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumer ready.
- `rsp_number` out 32: result, or qNaN on timeout.
- `rsp_id` out `IDW`: index of the requester that owns the response.
- `rsp_err` out 1: set to 1 when the job timed out.

## Operation
- State machine with five states: IDLE, SETUP, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` bit is set, grant the first set bit at or after `rr_ptr`, searching upward with wrap-around.
  - Pulse `req_ready[g]` for that cycle only.
  - Latch the granted requester's number, type, select and reverse into the job register, and latch g as the job ID.
  - Set `rr_ptr` to (g+1) mod `NREQ`.
  - Next state is SETUP.
- **SETUP:** `cv_type`, `cv_select`, `cv_reverse` and `cv_number_in` are driven from the job register; `cv_valid_in`=0. Next state is ISSUE.
- **ISSUE:** `cv_valid_in`=1 for exactly one cycle. Next state is WAIT, with the timeout counter cleared to 0.
- **WAIT:**
  - If `cv_valid_out`=1: capture `cv_number_out` into `rsp_number`, set `rsp_err`=0, go to RESP.
  - Otherwise, if the counter equals `TIMEOUT`-1: set `rsp_number`=32'h7FC00000 and `rsp_err`=1, go to RESP.
  - Otherwise, increment the counter.
  - If `cv_valid_out` arrives on the final timeout cycle, the valid result wins and `rsp_err`=0.
- **RESP:**
  - `rsp_valid`=1; `rsp_number`, `rsp_id` and `rsp_err` are held stable until `rsp_ready`=1.
  - On the handshake, go to IDLE. A new grant is issued no earlier than the following cycle.
- **Ignored inputs:** `cv_valid_out` is ignored in every state except WAIT, so late or spurious pulses are dropped. `req_valid` is ignored in every state except IDLE.
- **Stable converter controls:** `cv_*` control outputs hold the job register value in every state, so type, select and reverse stay constant for the whole job, including the temperature add/multiply chain.
- **Reset (asynchronous, including mid-job):**
  - State returns to IDLE; `rr_ptr`=0; the job register and all outputs go to 0.
  - `rsp_valid`, `rsp_err`, `cv_valid_in` and `req_ready` = 0.
  - Any in-flight job is dropped with no response.

## Timing
- Cycle 0: accept (`req_valid[g]` & `req_ready[g]`).
- Cycle 1: SETUP. Cycle 2: ISSUE, `cv_valid_in` high.
- From cycle 3: WAIT. If `cv_valid_out` is sampled high at cycle k, `rsp_valid` is high from cycle k+1.
- Timeout: `rsp_valid` with `rsp_err`=1 is asserted at cycle 3+`TIMEOUT`.
- Minimum spacing between grants is 5 cycles plus the converter latency.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `conv_pkg` holds:
  - the state enum;
  - the type codes `CONV_LEN`=0, `CONV_MASS`=1, `CONV_VOL`=2, `CONV_TEMP`=3;
  - `FP_QNAN`=32'h7FC00000.
- Sub-module `rr_arbiter`, parameterised by `NREQ`, takes `req`, `ptr` and `en` and returns a one-hot `grant` plus an encoded `grant_id`.
- Top level holds the FSM, job register, timeout counter and response register.

## Test plan
- Single job: requester 0 sends type 0, select 0, reverse 0, number 32'h3F800000 (1.0) → `rsp_number` 32'h41CB3333, `rsp_id` 0, `rsp_err` 0; `cv_valid_in` is high exactly at cycle 2.
- Temperature job: requester 1 sends type 3, reverse 0, number 32'h43540000 (212 °F) → 32'h42C80000 (100 °C); `cv_type` stays 3 until the response handshake.
- Round-robin order: all four `req_valid` held high → grant order 0,1,2,3,0. With the last grant at 2 and only requesters 0 and 3 pending → grant 3, then 0.
- Timeout: stub converter that never asserts `cv_valid_out` → at cycle 3+`TIMEOUT`, `rsp_valid`=1, `rsp_err`=1, `rsp_number` 32'h7FC00000. A later `cv_valid_out` pulse is ignored.
- Backpressure: `rsp_ready` held low for 10 cycles while other requests are pending → response fields stay stable and no `req_ready` pulses until the handshake.
- Reset mid-WAIT: assert `rst_n`=0 asynchronously → all outputs 0 and state IDLE immediately. A `cv_valid_out` pulse after reset release produces no response.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the converter scheduler.
// Holds the FSM state enum, converter type codes and the canonical quiet NaN.
package conv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StIssue,
        StWait,
        StResp
    } state_t;

    localparam logic [1:0] CONV_LEN  = 2'd0;
    localparam logic [1:0] CONV_MASS = 2'd1;
    localparam logic [1:0] CONV_VOL  = 2'd2;
    localparam logic [1:0] CONV_TEMP = 2'd3;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// searching upward with wrap-around.
module rr_arbiter #(
    parameter int unsigned  NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        idx      = '0;
        if (en) begin
            // Scan from the farthest slot back towards ptr so the nearest request wins.
            for (int k = int'(NREQ) - 1; k >= 0; k--) begin
                idx = IDW'((32'(ptr) + 32'(k)) % NREQ);
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    grant_id   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Shares one converter between NREQ requesters: round-robin accept, setup, issue,
// wait with timeout, then a tagged valid/ready response.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_number,
    input  logic [NREQ*2-1:0]   req_type,
    input  logic [NREQ*3-1:0]   req_select,
    input  logic [NREQ-1:0]     req_reverse,
    output logic [31:0]         cv_number_in,
    output logic                cv_valid_in,
    output logic [1:0]          cv_type,
    output logic [2:0]          cv_select,
    output logic                cv_reverse,
    input  logic [31:0]         cv_number_out,
    input  logic                cv_valid_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_number,
    output logic [IDW-1:0]      rsp_id,
    output logic                rsp_err
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  job_id;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant;
    logic [CW-1:0]   cnt;

    logic [31:0] num_arr [NREQ];
    logic [1:0]  type_arr [NREQ];
    logic [2:0]  sel_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign num_arr[i]  = req_number[32*i +: 32];
        assign type_arr[i] = req_type[2*i +: 2];
        assign sel_arr[i]  = req_select[3*i +: 3];
    end

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      ((state == StIdle) && (req_ready == '0)),
        .grant   (grant),
        .grant_id(grant_id)
    );

    // The cv_* control registers double as the job register, so they stay put for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            rr_ptr       <= '0;
            job_id       <= '0;
            cnt          <= '0;
            req_ready    <= '0;
            cv_number_in <= '0;
            cv_type      <= '0;
            cv_select    <= '0;
            cv_reverse   <= 1'b0;
            cv_valid_in  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_number   <= '0;
            rsp_id       <= '0;
            rsp_err      <= 1'b0;
        end else begin
            req_ready   <= '0;
            cv_valid_in <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Ready is registered: the handshake completes in the cycle it is high.
                    if (req_ready != '0) begin
                        cv_number_in <= num_arr[job_id];
                        cv_type      <= type_arr[job_id];
                        cv_select    <= sel_arr[job_id];
                        cv_reverse   <= req_reverse[job_id];
                        state        <= StSetup;
                    end else if (grant != '0) begin
                        req_ready <= grant;
                        job_id    <= grant_id;
                        rr_ptr    <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                StSetup: begin
                    cv_valid_in <= 1'b1;
                    state       <= StIssue;
                end
                StIssue: begin
                    cnt   <= '0;
                    state <= StWait;
                end
                StWait: begin
                    if (cv_valid_out) begin
                        rsp_number <= cv_number_out;
                        rsp_err    <= 1'b0;
                        rsp_id     <= job_id;
                        rsp_valid  <= 1'b1;
                        state      <= StResp;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_number <= FP_QNAN;
                        rsp_err    <= 1'b1;
                        rsp_id     <= job_id;
                        rsp_valid  <= 1'b1;
                        state      <= StResp;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
